// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR0,
    ADDR1,
    ADDR2,
    DATA0,
    DATA1,
    ISSUE,
    WAIT_RD,
    TX_LO,
    TX_HI,
    TX_ACK
  } state_t;

  localparam logic [7:0] OPC_RD   = 8'h00;
  localparam logic [7:0] OPC_WR   = 8'h01;
  localparam logic [7:0] ACK_BYTE = 8'h06;

endpackage

// File: rtl/uart_cmd_parser.sv
// Turns UART byte frames (opcode, addr LSB-first, optional wdata) into PSRAM requests.
// Define UART_CMD_WR_ACK_EN to echo ACK_BYTE on the UART after every write.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_cmd_we,
  output logic [23:0] o_cmd_addr,
  output logic [15:0] o_cmd_wdata,
  input  logic        i_rd_valid,
  input  logic [15:0] i_rd_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rd_hi;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      rd_hi       <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_we    <= 1'b0;
      o_cmd_addr  <= '0;
      o_cmd_wdata <= '0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (i_rx_valid) begin
            if (i_rx_data == OPC_RD || i_rx_data == OPC_WR) begin
              o_cmd_we <= (i_rx_data == OPC_WR);
              o_busy   <= 1'b1;
              state    <= ADDR0;
            end else begin
              o_err <= 1'b1;
            end
          end
        end

        ADDR0, ADDR1, ADDR2, DATA0, DATA1: begin
          if (i_rx_valid) begin
            tmo_cnt <= '0;
            case (state)
              ADDR0: begin
                o_cmd_addr[7:0] <= i_rx_data;
                state           <= ADDR1;
              end
              ADDR1: begin
                o_cmd_addr[15:8] <= i_rx_data;
                state            <= ADDR2;
              end
              ADDR2: begin
                o_cmd_addr[23:16] <= i_rx_data;
                if (o_cmd_we) begin
                  state <= DATA0;
                end else begin
                  state       <= ISSUE;
                  o_cmd_valid <= 1'b1;
                end
              end
              DATA0: begin
                o_cmd_wdata[7:0] <= i_rx_data;
                state            <= DATA1;
              end
              default: begin
                o_cmd_wdata[15:8] <= i_rx_data;
                state             <= ISSUE;
                o_cmd_valid       <= 1'b1;
              end
            endcase
          end else if (tmo_hit) begin
            // Stalled frame: drop whatever was collected so far.
            tmo_cnt <= '0;
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ISSUE: begin
          tmo_cnt <= '0;
          if (i_rx_valid) o_err <= 1'b1;
          if (i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
            if (o_cmd_we) begin
`ifdef UART_CMD_WR_ACK_EN
              o_tx_data  <= ACK_BYTE;
              o_tx_valid <= 1'b1;
              state      <= TX_ACK;
`else
              o_busy <= 1'b0;
              state  <= IDLE;
`endif
            end else if (i_rd_valid) begin
              // Fast controller: data returned in the same cycle as the accept.
              o_tx_data  <= i_rd_data[7:0];
              rd_hi      <= i_rd_data[15:8];
              o_tx_valid <= 1'b1;
              state      <= TX_LO;
            end else begin
              state <= WAIT_RD;
            end
          end
        end

        WAIT_RD: begin
          if (i_rx_valid) o_err <= 1'b1;
          if (i_rd_valid) begin
            tmo_cnt    <= '0;
            o_tx_data  <= i_rd_data[7:0];
            rd_hi      <= i_rd_data[15:8];
            o_tx_valid <= 1'b1;
            state      <= TX_LO;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        TX_LO: begin
          tmo_cnt <= '0;
          if (i_rx_valid) o_err <= 1'b1;
          if (i_tx_ready) begin
            o_tx_data <= rd_hi;
            state     <= TX_HI;
          end
        end

        TX_HI: begin
          tmo_cnt <= '0;
          if (i_rx_valid) o_err <= 1'b1;
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end

`ifdef UART_CMD_WR_ACK_EN
        TX_ACK: begin
          tmo_cnt <= '0;
          if (i_rx_valid) o_err <= 1'b1;
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end
`endif

        default: begin
          tmo_cnt     <= '0;
          o_cmd_valid <= 1'b0;
          o_tx_valid  <= 1'b0;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus queues expected requests, TX bytes
// and error pulses; a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_cmd_parser;

  localparam int TMO = 40;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic        o_cmd_we;
  logic [23:0] o_cmd_addr;
  logic [15:0] o_cmd_wdata;
  logic        i_rd_valid;
  logic [15:0] i_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_err = 0;
  cmd_t cmd_q[$];
  logic [7:0] tx_q[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready),
    .o_cmd_we   (o_cmd_we),
    .o_cmd_addr (o_cmd_addr),
    .o_cmd_wdata(o_cmd_wdata),
    .i_rd_valid (i_rd_valid),
    .i_rd_data  (i_rd_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", nm, act);
    end
  endtask

  // Monitor: every DUT handshake / pulse is matched against the scoreboard.
  always @(negedge clk) begin
    cmd_t c;
    logic [7:0] b;
    if (arst_n) begin
      if (o_cmd_valid && i_cmd_ready) begin
        if (cmd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_cmd: got we=%0b addr=%0h none expected", o_cmd_we, o_cmd_addr);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_we", 64'(o_cmd_we), 64'(c.we));
          check("cmd_addr", 64'(o_cmd_addr), 64'(c.addr));
          if (c.we) check("cmd_wdata", 64'(o_cmd_wdata), 64'(c.wdata));
        end
      end
      if (o_tx_valid && i_tx_ready) begin
        if (tx_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_tx: got %0h none expected", o_tx_data);
        end else begin
          b = tx_q.pop_front();
          check("tx_byte", 64'(o_tx_data), 64'(b));
        end
      end
      if (o_err) begin
        if (exp_err == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_err: got pulse expected none");
        end else begin
          exp_err--;
          check("err_pulse", 64'(o_err), 64'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick(1);
    i_rx_valid = 1'b0;
  endtask

  task automatic pulse_rd(input logic [15:0] d);
    i_rd_data  = d;
    i_rd_valid = 1'b1;
    tick(1);
    i_rd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (o_busy && k < 2000) begin
      tick(1);
      k++;
    end
    tick(2);
    check({nm, "_idle"}, 64'(o_busy), 64'd0);
    check({nm, "_err_drained"}, 64'(exp_err), 64'd0);
    check({nm, "_cmd_drained"}, 64'(cmd_q.size()), 64'd0);
    check({nm, "_tx_drained"}, 64'(tx_q.size()), 64'd0);
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [15:0] d);
    cmd_q.push_back({1'b1, a, d});
`ifdef UART_CMD_WR_ACK_EN
    tx_q.push_back(8'h06);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    arst_n = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_cmd_ready = 1'b1;
    i_rd_valid = 1'b0; i_rd_data = '0; i_tx_ready = 1'b1;
    #12;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_cmd_valid", 64'(o_cmd_valid), 64'd0);
    check("rst_tx_valid", 64'(o_tx_valid), 64'd0);
    check("rst_outs", {o_cmd_we, o_cmd_addr, o_cmd_wdata, o_tx_data, o_err}, 64'd0);
    @(posedge clk); #1 arst_n = 1'b1;
    tick(2);

    // Write frame
    push_wr(24'h040302, 16'h0708);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h08); send_byte(8'h07);
    wait_idle("write");

    // Read frame, data returned a few cycles after accept
    cmd_q.push_back({1'b0, 24'h040302, 16'h0000});
    tx_q.push_back(8'h08); tx_q.push_back(8'h07);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    tick(3);
    pulse_rd(16'h0708);
    wait_idle("read");

    // Illegal opcode
    exp_err++;
    send_byte(8'h55);
    check("bad_opc_busy", 64'(o_busy), 64'd0);
    tick(1);
    check("bad_opc_busy2", 64'(o_busy), 64'd0);
    wait_idle("bad_opc");

    // Partial frame timeout: still busy just before the limit, idle after
    send_byte(8'h01); send_byte(8'h02);
    tick(TMO - 5);
    check("tmo_not_yet", 64'(o_busy), 64'd1);
    exp_err++;
    tick(10);
    check("tmo_idle", 64'(o_busy), 64'd0);
    push_wr(24'h0C0B0A, 16'hBEEF);
    send_byte(8'h01); send_byte(8'h0A); send_byte(8'h0B);
    send_byte(8'h0C); send_byte(8'hEF); send_byte(8'hBE);
    wait_idle("after_tmo");

    // Read-data timeout in WAIT_RD
    cmd_q.push_back({1'b0, 24'h000001, 16'h0000});
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    exp_err++;
    tick(TMO + 10);
    wait_idle("rd_tmo");

    // Long ready stall with a stray rx byte: request must hold, no timeout
    i_cmd_ready = 1'b0;
    push_wr(24'hCCBBAA, 16'h3344);
    send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    send_byte(8'hCC); send_byte(8'h44); send_byte(8'h33);
    tick(250);
    check("stall_valid_mid", 64'(o_cmd_valid), 64'd1);
    exp_err++;
    send_byte(8'h99);
    tick(249);
    check("stall_valid", 64'(o_cmd_valid), 64'd1);
    check("stall_fields", {o_cmd_we, o_cmd_addr, o_cmd_wdata}, {1'b1, 24'hCCBBAA, 16'h3344});
    check("stall_busy", 64'(o_busy), 64'd1);
    i_cmd_ready = 1'b1;
    wait_idle("stall");

    // Read data in the accept cycle, with TX back-pressure on the low byte
    i_cmd_ready = 1'b0;
    i_tx_ready  = 1'b0;
    cmd_q.push_back({1'b0, 24'h302010, 16'h0000});
    tx_q.push_back(8'h08); tx_q.push_back(8'h07);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    i_cmd_ready = 1'b1;
    pulse_rd(16'h0708);
    tick(20);
    check("txhold_valid", 64'(o_tx_valid), 64'd1);
    check("txhold_data", 64'(o_tx_data), 64'h08);
    i_tx_ready = 1'b1;
    wait_idle("same_cycle_rd");

    // Reset after the 3rd byte of a write; following read completes normally
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    arst_n = 1'b0;
    tick(2);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_addr", 64'(o_cmd_addr), 64'd0);
    arst_n = 1'b1;
    tick(10);
    check("postrst_no_cmd", 64'(o_cmd_valid), 64'd0);
    cmd_q.push_back({1'b0, 24'h070605, 16'h0000});
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    tick(2);
    pulse_rd(16'hBEEF);
    wait_idle("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
